// File: rtl/seq_multiplier_8bit.sv
// Sequential 8x8 unsigned shift-and-add multiplier around a single 8-bit adder.
// Optional feature: define MUL_ZERO_BYPASS_EN to finish zero-operand multiplies in one cycle.

module adder_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Cout
);
  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {8'b0, Cin};
endmodule

module seq_multiplier_8bit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] mcand, hi, lo;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] add_sum, step_s;
  logic             add_cout, step_c;
  logic             accept, zero_op;

  adder_8bit u_adder (
    .A    (hi),
    .B    (mcand),
    .Cin  (1'b0),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
  assign accept = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    if (lo[0]) begin
      step_c = add_cout;
      step_s = add_sum;
    end else begin
      step_c = 1'b0;
      step_s = hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = zero_op ? DONE : RUN;
      RUN:  if (cnt == 3'd7) state_nx = DONE;
      DONE: begin
        if (accept) state_nx = zero_op ? DONE : RUN;
        else        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mcand <= a;
      lo    <= b;
      hi    <= '0;
      cnt   <= '0;
      if (zero_op) product <= '0;
    end else if (state == RUN) begin
      // The 17-bit {c,s,lo} shifted right by one fits exactly in {hi,lo}.
      hi  <= {step_c, step_s[WIDTH-1:1]};
      lo  <= {step_s[0], lo[WIDTH-1:1]};
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) product <= {step_c, step_s, lo[WIDTH-1:1]};
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier_8bit.sv
// Self-checking bench for seq_multiplier_8bit: timeline model plus directed vectors.
// Build with +define+MUL_ZERO_BYPASS_EN to exercise the zero-operand bypass.

module tb_seq_multiplier_8bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy, done;
  logic [15:0] product;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

`ifdef MUL_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int ZERO_DONE_EDGE = BYPASS ? 0 : 8;

  seq_multiplier_8bit #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Timeline model: a result is owed 8 edges after acceptance (or at once for a
  // bypassed zero operand); a start is accepted whenever no result is owed.
  int          m_cycle, m_finish;
  bit          m_owed;
  logic [15:0] m_pending, m_product;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cycle   <= 0;
      m_finish  <= -100;
      m_owed    <= 1'b0;
      m_pending <= '0;
      m_product <= '0;
    end else begin
      m_cycle <= m_cycle + 1;
      if (m_owed) begin
        if (m_cycle + 1 == m_finish) begin
          m_product <= m_pending;
          m_owed    <= 1'b0;
        end
      end else if (start) begin
        if (BYPASS && (a == 0 || b == 0)) begin
          m_product <= 16'd0;
          m_finish  <= m_cycle + 1;
        end else begin
          m_owed    <= 1'b1;
          m_pending <= 16'(a * b);
          m_finish  <= m_cycle + 9;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    check("busy_vs_model",    32'(busy),    32'(m_owed));
    check("done_vs_model",    32'(done),    32'(rst_n && (m_cycle == m_finish)));
    check("product_vs_model", 32'(product), 32'(m_product));
  end

  // Waits (bounded) for done; returns the edge index, relative to e0, at which it rose.
  task automatic wait_done(input int e0, output int edge_idx);
    int guard = 0;
    while (!done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!done) check("done_timeout", 32'(0), 32'(1));
    edge_idx = cyc - 1 - e0;
  endtask

  task automatic do_mul(input string name, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [15:0] want, input int want_edge);
    int e0, e;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk);
    e0 = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_done(e0, e);
    check({name, "_done_edge"}, 32'(e), 32'(want_edge));
    check({name, "_product"}, 32'(product), 32'(want));
    @(negedge clk);
    check({name, "_done_one_cycle"}, 32'(done), 32'(0));
  endtask

  initial begin
    int e0, e;
    #12;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_product", 32'(product), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    do_mul("mul_3x5",    8'd3,   8'd5,   16'd15,    8);
    do_mul("mul_ffxff",  8'hFF,  8'hFF,  16'hFE01,  8);
    do_mul("mul_80x02",  8'h80,  8'h02,  16'h0100,  8);
    do_mul("mul_1x1",    8'd1,   8'd1,   16'd1,     8);
    do_mul("mul_ffx01",  8'hFF,  8'h01,  16'd255,   8);
    do_mul("mul_0x200",  8'd0,   8'd200, 16'd0,     ZERO_DONE_EDGE);
    do_mul("mul_5x0",    8'd5,   8'd0,   16'd0,     ZERO_DONE_EDGE);

    // Start while busy: second start at E3 must be ignored.
    @(negedge clk);
    a = 8'd7; b = 8'd9; start = 1'b1;
    @(posedge clk);
    e0 = cyc;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_mid_run", 32'(busy), 32'(1));
    wait_done(e0, e);
    check("ignore_start_done_edge", 32'(e), 32'(8));
    check("ignore_start_product", 32'(product), 32'(63));
    @(negedge clk);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 8'd10; b = 8'd20; start = 1'b1;
    @(posedge clk);
    e0 = cyc;
    @(negedge clk);
    wait_done(e0, e);
    check("b2b_first_done_edge", 32'(e), 32'(8));
    check("b2b_first_product", 32'(product), 32'(200));
    a = 8'd200; b = 8'd3;
    @(negedge clk);
    check("b2b_done_drops", 32'(done), 32'(0));
    check("b2b_busy_again", 32'(busy), 32'(1));
    wait_done(e0, e);
    check("b2b_second_done_edge", 32'(e), 32'(17));
    check("b2b_second_product", 32'(product), 32'(600));
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset in the middle of a run.
    @(negedge clk);
    a = 8'd12; b = 8'd12; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_product", 32'(product), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    do_mul("after_rst_2x2", 8'd2, 8'd2, 16'd4, 8);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
